// File: rtl/battery_pkg.sv
// -----------------------------------------------------------------------------
// battery_pkg
// Shared definitions for the battery manager slice: fan-state encodings,
// default level constants and a small level-classification helper.
// Optional feature macro used by this slice: BATTERY_LOW_FLAG_EN.
// -----------------------------------------------------------------------------
package battery_pkg;

  // Fan state as seen on the 2-bit state input; 11 behaves like high speed.
  typedef enum logic [1:0] {
    FAN_IDLE     = 2'b00,
    FAN_LOW      = 2'b01,
    FAN_HIGH     = 2'b10,
    FAN_HIGH_ALT = 2'b11
  } fan_state_e;

  localparam int unsigned BATTERY_W          = 8;
  localparam int unsigned DEFAULT_FULL_LEVEL = 99;
  localparam int unsigned DEFAULT_LOW_LEVEL  = 10;

  // Low means "nearly empty": at or below the threshold but not yet zero.
  function automatic logic level_is_low(input logic [BATTERY_W-1:0] level,
                                        input logic [BATTERY_W-1:0] low_level);
    return (level <= low_level) && (level != 8'd0);
  endfunction

endpackage

// File: rtl/battery_manager_if.sv
// -----------------------------------------------------------------------------
// battery_if
// Groups the mode inputs, timer ticks and level outputs of battery_manager.
//   master : drives sw0, state, timer_100ms, timer_200ms; reads the outputs
//   slave  : the battery manager itself
// When BATTERY_LOW_FLAG_EN is defined the interface also carries battery_low.
// -----------------------------------------------------------------------------
interface battery_if;
  logic       sw0;           // 1 = charger connected
  logic [1:0] state;         // fan state
  logic       timer_100ms;   // one-clk tick every 100 ms
  logic       timer_200ms;   // one-clk tick every 200 ms
  logic [7:0] battery;       // current level, 0..FULL_LEVEL
  logic       battery_empty; // level == 0
`ifdef BATTERY_LOW_FLAG_EN
  logic       battery_low;   // 0 < level <= LOW_LEVEL

  modport master (output sw0, state, timer_100ms, timer_200ms,
                  input  battery, battery_empty, battery_low);
  modport slave  (input  sw0, state, timer_100ms, timer_200ms,
                  output battery, battery_empty, battery_low);
`else
  modport master (output sw0, state, timer_100ms, timer_200ms,
                  input  battery, battery_empty);
  modport slave  (input  sw0, state, timer_100ms, timer_200ms,
                  output battery, battery_empty);
`endif
endinterface

// File: rtl/battery_rate_sel.sv
// -----------------------------------------------------------------------------
// battery_rate_sel
// Picks which timer tick moves the battery level for the current mode.
//   sw0, state             : operating mode (charge / discharge, fan speed)
//   timer_100ms/200ms      : raw ticks
//   inc_en / dec_en        : one-clk step request; mutually exclusive because
//                            sw0 selects exactly one of them.
// Only the tick belonging to the current mode is looked at, so a clk with
// both ticks high still produces a single step.
// -----------------------------------------------------------------------------
module battery_rate_sel
  import battery_pkg::*;
(
  input  logic       sw0,
  input  logic [1:0] state,
  input  logic       timer_100ms,
  input  logic       timer_200ms,
  output logic       inc_en,
  output logic       dec_en
);

  fan_state_e fan_s;
  assign fan_s = fan_state_e'(state);

  // Mode decode: charging is fast when idle, discharging is fast at high speed.
  always_comb begin
    inc_en = 1'b0;
    dec_en = 1'b0;
    if (sw0) begin
      case (fan_s)
        FAN_IDLE:                     inc_en = timer_100ms;
        FAN_LOW, FAN_HIGH, FAN_HIGH_ALT: inc_en = timer_200ms;
        default:                      inc_en = 1'b0;
      endcase
    end else begin
      case (fan_s)
        FAN_IDLE:             dec_en = 1'b0;
        FAN_LOW:              dec_en = timer_200ms;
        FAN_HIGH, FAN_HIGH_ALT: dec_en = timer_100ms;
        default:              dec_en = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/battery_manager.sv
// -----------------------------------------------------------------------------
// battery_manager
// Keeps a saturating battery level that charges or discharges one step per
// qualifying timer tick.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, level returns to FULL_LEVEL
//   bus  : battery_if.slave (sw0, state, ticks in; battery, battery_empty out)
// Parameters: FULL_LEVEL (max and reset level), LOW_LEVEL (low-flag threshold).
// Optional: define BATTERY_LOW_FLAG_EN to add bus.battery_low.
// -----------------------------------------------------------------------------
module battery_manager
  import battery_pkg::*;
#(
  parameter int unsigned FULL_LEVEL = DEFAULT_FULL_LEVEL,
  parameter int unsigned LOW_LEVEL  = DEFAULT_LOW_LEVEL
) (
  input  logic     clk,
  input  logic     rst,
  battery_if.slave bus
);

  localparam logic [7:0] FULL_LVL = 8'(FULL_LEVEL);
  localparam logic [7:0] LOW_LVL  = 8'(LOW_LEVEL);

  logic [7:0] battery_q;
  logic [7:0] battery_d;
  logic       inc_en_s;
  logic       dec_en_s;

  battery_rate_sel u_rate_sel (
    .sw0         (bus.sw0),
    .state       (bus.state),
    .timer_100ms (bus.timer_100ms),
    .timer_200ms (bus.timer_200ms),
    .inc_en      (inc_en_s),
    .dec_en      (dec_en_s)
  );

  // Next level: single step, clamped at both ends so it never wraps.
  always_comb begin
    battery_d = battery_q;
    if (inc_en_s && (battery_q < FULL_LVL)) begin
      battery_d = battery_q + 8'd1;
    end else if (dec_en_s && (battery_q != 8'd0)) begin
      battery_d = battery_q - 8'd1;
    end else begin
      battery_d = battery_q;
    end
  end

  // Level register; reset wins over any tick in the same clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      battery_q <= FULL_LVL;
    end else begin
      battery_q <= battery_d;
    end
  end

  assign bus.battery       = battery_q;
  assign bus.battery_empty = (battery_q == 8'd0);

`ifdef BATTERY_LOW_FLAG_EN
  // Forced low during reset so the flag never glitches while the level reloads.
  assign bus.battery_low = !rst && level_is_low(battery_q, LOW_LVL);
`else
  logic unused_low_level_s;
  assign unused_low_level_s = ^LOW_LVL;
`endif

endmodule

// File: tb/tb_battery_manager.sv
// -----------------------------------------------------------------------------
// tb_battery_manager
// Directed stimulus with hand-computed checkpoints. Stimulus pushes expected
// levels into a scoreboard queue and raises chk for one clk; a separate
// monitor pops and compares one entry per strobed cycle.
// -----------------------------------------------------------------------------
module tb_battery_manager;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk = 1'b0;

  always #5 clk = ~clk;

  battery_if bif();

  battery_manager #(
    .FULL_LEVEL (99),
    .LOW_LEVEL  (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    string      name;
    logic [7:0] bat;
    logic       empty;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Monitor: compares away from the edge, one scoreboard entry per strobe.
  always @(posedge clk) begin
    #1;
    if (chk) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: strobe with no expected entry");
      end else begin
        mon_e = sb_q.pop_front();
        n_cmp++;
        if (bif.battery !== mon_e.bat) begin
          n_fail++;
          $display("FAIL %s battery: got %0d expected %0d", mon_e.name, bif.battery, mon_e.bat);
        end
        n_cmp++;
        if (bif.battery_empty !== mon_e.empty) begin
          n_fail++;
          $display("FAIL %s empty: got %b expected %b", mon_e.name, bif.battery_empty, mon_e.empty);
        end
`ifdef BATTERY_LOW_FLAG_EN
        n_cmp++;
        if (bif.battery_low !== ((mon_e.bat <= 8'd10) && (mon_e.bat != 8'd0))) begin
          n_fail++;
          $display("FAIL %s low: got %b for level %0d", mon_e.name, bif.battery_low, mon_e.bat);
        end
`endif
      end
    end
  end

  task automatic set_mode(input logic sw, input logic [1:0] st);
    @(negedge clk);
    bif.sw0   = sw;
    bif.state = st;
  endtask

  task automatic tick(input logic t100, input logic t200, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bif.timer_100ms = t100;
      bif.timer_200ms = t200;
      @(negedge clk);
      bif.timer_100ms = 1'b0;
      bif.timer_200ms = 1'b0;
    end
  endtask

  task automatic expect_lvl(input string name, input logic [7:0] bat, input logic empty);
    exp_t e;
    e.name  = name;
    e.bat   = bat;
    e.empty = empty;
    sb_q.push_back(e);
    @(negedge clk);
    chk = 1'b1;
    @(negedge clk);
    chk = 1'b0;
  endtask

  initial begin
    bif.sw0         = 1'b0;
    bif.state       = 2'b00;
    bif.timer_100ms = 1'b0;
    bif.timer_200ms = 1'b0;
    rst             = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_lvl("reset", 8'd99, 1'b0);

    // Discharge at low speed: only the 200 ms tick counts.
    set_mode(1'b0, 2'b01);
    tick(1'b1, 1'b0, 5);
    expect_lvl("dis_low_100_ignored", 8'd99, 1'b0);
    tick(1'b0, 1'b1, 25);
    expect_lvl("dis_low_25", 8'd74, 1'b0);
    tick(1'b0, 1'b1, 25);
    expect_lvl("dis_low_50", 8'd49, 1'b0);

    // High speed ignores the 200 ms tick.
    set_mode(1'b0, 2'b10);
    tick(1'b0, 1'b1, 3);
    expect_lvl("dis_high_200_ignored", 8'd49, 1'b0);

    // Reload then run down to empty.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_lvl("reset_reload", 8'd99, 1'b0);
    tick(1'b1, 1'b0, 98);
    expect_lvl("dis_high_98", 8'd1, 1'b0);
    tick(1'b1, 1'b0, 1);
    expect_lvl("dis_high_99_empty", 8'd0, 1'b1);
    tick(1'b1, 1'b0, 5);
    expect_lvl("dis_floor", 8'd0, 1'b1);

    // Discharge while idle holds.
    set_mode(1'b0, 2'b00);
    tick(1'b1, 1'b1, 3);
    expect_lvl("dis_idle_hold", 8'd0, 1'b1);

    // Idle charge on 100 ms ticks.
    set_mode(1'b1, 2'b00);
    tick(1'b1, 1'b0, 10);
    expect_lvl("chg_idle_10", 8'd10, 1'b0);
    tick(1'b0, 1'b1, 2);
    expect_lvl("chg_idle_200_ignored", 8'd10, 1'b0);

    // Running charge on 200 ms ticks, then saturation at full.
    set_mode(1'b1, 2'b01);
    tick(1'b0, 1'b1, 10);
    expect_lvl("chg_run_10", 8'd20, 1'b0);
    tick(1'b1, 1'b0, 3);
    expect_lvl("chg_run_100_ignored", 8'd20, 1'b0);
    set_mode(1'b1, 2'b11);
    tick(1'b0, 1'b1, 79);
    expect_lvl("chg_run_full", 8'd99, 1'b0);
    tick(1'b0, 1'b1, 1);
    expect_lvl("chg_saturate", 8'd99, 1'b0);

    // Both ticks in the same clk: exactly one step.
    set_mode(1'b0, 2'b01);
    tick(1'b1, 1'b1, 1);
    expect_lvl("both_dis_low", 8'd98, 1'b0);
    set_mode(1'b0, 2'b11);
    tick(1'b1, 1'b1, 1);
    expect_lvl("both_dis_high_alt", 8'd97, 1'b0);
    set_mode(1'b1, 2'b00);
    tick(1'b1, 1'b1, 1);
    expect_lvl("both_chg_idle", 8'd98, 1'b0);
    set_mode(1'b1, 2'b10);
    tick(1'b1, 1'b1, 1);
    expect_lvl("both_chg_high", 8'd99, 1'b0);

    // Reset coincident with a tick, mid-charge.
    set_mode(1'b0, 2'b10);
    tick(1'b1, 1'b0, 3);
    expect_lvl("pre_rst_dis", 8'd96, 1'b0);
    set_mode(1'b1, 2'b00);
    tick(1'b1, 1'b0, 1);
    expect_lvl("pre_rst_chg", 8'd97, 1'b0);
    @(negedge clk);
    rst             = 1'b1;
    bif.timer_100ms = 1'b1;
    bif.timer_200ms = 1'b1;
    @(negedge clk);
    rst             = 1'b0;
    bif.timer_100ms = 1'b0;
    bif.timer_200ms = 1'b0;
    expect_lvl("rst_over_tick", 8'd99, 1'b0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries remain, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/battery_manager.md
BATTERY_MANAGER -- requirements
Module: battery_manager

Interface
- REQ-001 SHALL have parameter FULL_LEVEL, default 99: maximum battery level and reset value.
- REQ-002 SHALL have parameter LOW_LEVEL, default 10: threshold for the optional low flag.
- REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-005 SHALL have port sw0, input, 1 bit: 1 = charger connected (charge mode), 0 = discharge mode.
- REQ-006 SHALL have port state, input, 2 bits: fan state; 00 idle, 01 low speed, 10 high speed, 11 treated as high speed.
- REQ-007 SHALL have port timer_100ms, input, 1 bit: one-clk-wide tick every 100 ms.
- REQ-008 SHALL have port timer_200ms, input, 1 bit: one-clk-wide tick every 200 ms.
- REQ-009 SHALL have port battery, output, 8 bits: unsigned level, always within 0..FULL_LEVEL.
- REQ-010 SHALL have port battery_empty, output, 1 bit: high exactly when battery == 0.

Function
- REQ-011 SHALL keep battery in a register that changes only on a qualifying tick, by at most 1 per clk.
- REQ-012 SHALL, when sw0=1 and state=00, increment battery by 1 on each timer_100ms tick.
- REQ-013 SHALL, when sw0=1 and state!=00, increment battery by 1 on each timer_200ms tick and ignore timer_100ms.
- REQ-014 SHALL saturate charging at FULL_LEVEL; further ticks at FULL_LEVEL leave battery unchanged.
- REQ-015 SHALL, when sw0=0 and state=01, decrement battery by 1 on each timer_200ms tick.
- REQ-016 SHALL, when sw0=0 and state=10 or 11, decrement battery by 1 on each timer_100ms tick.
- REQ-017 SHALL, when sw0=0 and state=00, hold battery unchanged.
- REQ-018 SHALL saturate discharging at 0; no wrap to 255.
- REQ-019 SHALL use only the tick selected by the current mode when both ticks are high in the same clk.
- REQ-020 SHALL sample sw0 and state every clk; a mode change takes effect on the next qualifying tick.
- REQ-021 SHALL drive battery_empty combinationally from the battery register, with zero-cycle latency relative to battery.

Reset
- REQ-022 SHALL set battery to FULL_LEVEL and battery_empty to 0 on the clk edge where rst=1.
- REQ-023 SHALL give rst priority over any concurrent tick, including when asserted mid-charge or mid-discharge.

Configuration
- REQ-024 SHALL, when macro BATTERY_LOW_FLAG_EN is defined, add output battery_low (1 bit) that is high when battery <= LOW_LEVEL and battery != 0, and 0 during reset.
- REQ-025 SHALL, when BATTERY_LOW_FLAG_EN is undefined, omit the battery_low port and its logic entirely.

Structure
- REQ-026 SHALL put the fan-state encodings (IDLE=00, LOW=01, HIGH=10, HIGH_ALT=11) and default level constants in shared package battery_pkg.
- REQ-027 SHALL use one sub-module, battery_rate_sel, that takes sw0, state and both ticks and returns inc_en and dec_en, which are never both 1; the level register stays in battery_manager.

Verification
- REQ-028 Reset: rst=1 for 2 clk -> battery=99, battery_empty=0.
- REQ-029 Discharge low: sw0=0, state=01, 50 timer_200ms ticks from 99 -> battery=49; 100ms ticks alone cause no change.
- REQ-030 Discharge to empty: sw0=0, state=10, 99 timer_100ms ticks -> battery=0 and battery_empty=1; 5 more ticks keep battery=0.
- REQ-031 Idle charge: from 0, sw0=1, state=00, 10 timer_100ms ticks -> battery=10, battery_empty=0.
- REQ-032 Run charge and saturation: sw0=1, state=01, 10 timer_200ms ticks from 10 -> 20; continue until 99, one extra tick -> stays 99.
- REQ-033 Reset mid-operation and simultaneous ticks: both ticks high with sw0=0, state=01 -> exactly -1; rst=1 coincident with a tick -> battery=99.
